// File: rtl/instr_fetch_19bit.sv
// Fetch stage for the 4K x 19-bit memory: owns the PC, captures the combinationally
// read word into a 2-entry buffer and hands {pc, instruction} to decode.
module instr_fetch_19bit #(
  parameter int              ADDR_W   = 12,
  parameter int              DATA_W   = 19,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [4:0]      HALT_OP  = 5'h1F,
  parameter int              DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ins;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        count;
  entry_t [1:0]      ent_q;   // [0] is always the head
  entry_t            fetched;
  logic              fetch, pop, hit_halt;

  assign fetch    = (state_q == RUN) && (count < 2'(DEPTH)) && !redirect;
  assign pop      = (count != 2'd0) && ir_ready;
  assign hit_halt = fetch && (mem_dataOut[DATA_W-1 -: 5] == HALT_OP);
  assign fetched  = '{pc: pc, ins: mem_dataOut};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en && !redirect) state_d = RUN;
      RUN:     if (hit_halt) state_d = HALT;
      HALT:    if (redirect) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      count <= 2'd0;
      ent_q <= '0;
    end else if (redirect) begin
      // flush wins over any pop in the same cycle
      pc    <= redirect_pc;
      count <= 2'd0;
    end else begin
      if (fetch) pc <= pc + 1'b1;
      case ({fetch, pop})
        2'b01: begin
          ent_q[0] <= ent_q[1];
          count    <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) ent_q[0] <= fetched;
          else               ent_q[1] <= fetched;
          count <= count + 2'd1;
        end
        // fetch implies count<2 and pop implies count>0, so count is 1 here
        2'b11: ent_q[0] <= fetched;
        default: ;
      endcase
    end
  end

  assign ir_valid   = (count != 2'd0);
  assign ir_out     = ir_valid ? ent_q[0].ins : '0;
  assign pc_out     = ir_valid ? ent_q[0].pc  : '0;
  assign mem_addr   = pc;
  assign mem_rd     = fetch;
  assign mem_wr     = 1'b0;
  assign mem_dataIn = '0;
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch_19bit.sv
// Bench for instr_fetch_19bit: memory model, queue-based reference model checked
// every cycle, plus directed literal checks.
module tb_instr_fetch_19bit;

  logic        clk = 1'b0;
  logic        rst, en, redirect, ir_ready;
  logic [11:0] redirect_pc;
  logic [11:0] mem_addr, pc_out;
  logic        mem_rd, mem_wr, ir_valid, halted;
  logic [18:0] mem_dataIn, mem_dataOut, ir_out;

  logic [18:0] mem [0:4095];
  assign mem_dataOut = mem[mem_addr];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_fetch_19bit dut (
    .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dataIn(mem_dataIn),
    .mem_dataOut(mem_dataOut), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_out(ir_out), .pc_out(pc_out), .halted(halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of delivered {pc,word} pairs and a simple run/halt flag pair.
  typedef struct packed { logic [11:0] pc; logic [18:0] ins; } ent_t;
  ent_t q[$];
  int   m_pc;
  bit   m_run, m_halt, m_live;

  always @(posedge clk) begin
    bit f, p;
    if (rst) begin
      q.delete(); m_pc = 0; m_run = 0; m_halt = 0; m_live = 1;
    end else if (m_live) begin
      if (redirect) begin
        q.delete(); m_pc = int'(redirect_pc);
        if (m_halt) begin m_halt = 0; m_run = 1; end
      end else begin
        f = m_run && !m_halt && q.size() < 2;
        p = q.size() != 0 && ir_ready;
        if (p) void'(q.pop_front());
        if (f) begin
          q.push_back('{pc: 12'(m_pc), ins: mem[m_pc]});
          if (mem[m_pc][18:14] == 5'h1F) m_halt = 1;
          m_pc = (m_pc + 1) % 4096;
        end
        if (!m_run && !m_halt && en) m_run = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_valid", 32'(ir_valid), 32'(q.size() != 0));
      chk("m_ir",    32'(ir_out),   q.size() != 0 ? 32'(q[0].ins) : 32'd0);
      chk("m_pc",    32'(pc_out),   q.size() != 0 ? 32'(q[0].pc)  : 32'd0);
      chk("m_addr",  32'(mem_addr), 32'(m_pc));
      chk("m_rd",    32'(mem_rd),   32'(m_run && !m_halt && q.size() < 2 && !redirect));
      chk("m_halt",  32'(halted),   32'(m_halt));
      chk("m_wr",    32'({mem_wr, mem_dataIn}), 32'd0);
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[0] = 19'h00011; mem[1] = 19'h00022; mem[2] = 19'h00033; mem[3] = 19'h00044;
    mem[4] = 19'h00055; mem[5] = 19'h7C000;
    mem[40] = 19'h12345; mem[41] = 19'h00777; mem[4095] = 19'h0ABCD;
    rst = 1; en = 0; redirect = 0; redirect_pc = '0; ir_ready = 1;
    tick; tick;
    rst = 0;

    // reset state / idle
    at_neg;
    chk("rst_rd", 32'(mem_rd), 0); chk("rst_valid", 32'(ir_valid), 0);
    chk("rst_addr", 32'(mem_addr), 0); chk("rst_halt", 32'(halted), 0);
    chk("rst_ir", 32'(ir_out), 0);
    tick; en = 1;
    at_neg; chk("trans_rd", 32'(mem_rd), 0);
    tick; en = 0;
    at_neg; chk("f0_rd", 32'(mem_rd), 1); chk("f0_addr", 32'(mem_addr), 0);
    tick; at_neg; chk("s_ir0", 32'(ir_out), 32'h11); chk("s_pc0", 32'(pc_out), 0);
    tick; at_neg; chk("s_ir1", 32'(ir_out), 32'h22); chk("s_pc1", 32'(pc_out), 1);
    tick; at_neg; chk("s_ir2", 32'(ir_out), 32'h33); chk("s_pc2", 32'(pc_out), 2);

    // halt word at pc 5
    begin
      int k = 0;
      while (!(ir_valid && pc_out == 12'd5) && k < 20) begin tick; at_neg; k++; end
      chk("halt_seen", 32'(k < 20), 1);
    end
    chk("halt_ir", 32'(ir_out), 32'h7C000); chk("halt_flag", 32'(halted), 1);
    for (int i = 0; i < 10; i++) begin tick; at_neg; chk("halt_rd", 32'(mem_rd), 0); end
    tick; redirect = 1; redirect_pc = 12'd0;
    at_neg; chk("hredir_rd", 32'(mem_rd), 0);
    tick; redirect = 0;
    at_neg; chk("resume_halt", 32'(halted), 0); chk("resume_rd", 32'(mem_rd), 1);
    chk("resume_addr", 32'(mem_addr), 0);

    // reset mid-fetch with one entry buffered
    tick; at_neg; chk("mid_valid", 32'(ir_valid), 1); chk("mid_rd", 32'(mem_rd), 1);
    tick; rst = 1;
    tick; rst = 0;
    at_neg; chk("mr_valid", 32'(ir_valid), 0); chk("mr_rd", 32'(mem_rd), 0);
    chk("mr_addr", 32'(mem_addr), 0);
    tick; tick; at_neg; chk("mr_noen_rd", 32'(mem_rd), 0);

    // backpressure
    ir_ready = 0; en = 1;
    tick; en = 0;
    at_neg; chk("bp_rd0", 32'(mem_rd), 1);
    tick; at_neg; chk("bp_rd1", 32'(mem_rd), 1);
    for (int i = 0; i < 3; i++) begin
      tick; at_neg;
      chk("bp_full_rd", 32'(mem_rd), 0); chk("bp_addr", 32'(mem_addr), 2);
      chk("bp_ir", 32'(ir_out), 32'h11); chk("bp_pc", 32'(pc_out), 0);
    end
    tick; ir_ready = 1;
    at_neg; chk("bp_o0", 32'(ir_out), 32'h11);
    tick; at_neg; chk("bp_o1", 32'(ir_out), 32'h22); chk("bp_p1", 32'(pc_out), 1);
    tick; at_neg; chk("bp_o2", 32'(ir_out), 32'h33); chk("bp_p2", 32'(pc_out), 2);

    // redirect while full
    tick; ir_ready = 0;
    tick; tick; tick;
    at_neg; chk("rd_full_rd", 32'(mem_rd), 0); chk("rd_full_v", 32'(ir_valid), 1);
    tick; redirect = 1; redirect_pc = 12'd40;
    at_neg; chk("rd_cyc_rd", 32'(mem_rd), 0);
    tick; redirect = 0; ir_ready = 1;
    at_neg; chk("rd_valid", 32'(ir_valid), 0); chk("rd_rd", 32'(mem_rd), 1);
    chk("rd_addr", 32'(mem_addr), 40);
    tick; at_neg; chk("rd_ir", 32'(ir_out), 32'h12345); chk("rd_pc", 32'(pc_out), 40);

    // wrap
    tick; redirect = 1; redirect_pc = 12'd4095;
    tick; redirect = 0;
    tick; at_neg; chk("wr_pc0", 32'(pc_out), 4095); chk("wr_ir0", 32'(ir_out), 32'h0ABCD);
    tick; at_neg; chk("wr_pc1", 32'(pc_out), 0); chk("wr_ir1", 32'(ir_out), 32'h11);
    tick; at_neg; chk("wr_pc2", 32'(pc_out), 1);

    tick; tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
